// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse-data path: default geometry, word type, FSM states,
// and the rank-to-lane mapping that the compressor and the decompressor must agree on.
package sparse_pkg;
  localparam int DEF_WORD_L     = 8;
  localparam int DEF_IN_PORT_L  = 4;
  localparam int DEF_OUT_PORT_L = 8;

  typedef logic [DEF_WORD_L-1:0] word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } comp_state_t;

  // The decompressor selects a lane by the inclusive prefix count of the header,
  // so a word of rank j lands in lane (j+1) mod lanes.
  function automatic int lane_of_rank(input int rank, input int lanes);
    return (rank + 1) % lanes;
  endfunction
endpackage

// File: rtl/compressor_if.sv
// Dense-in / compressed-out handshake bundle; slave = compressor side, master = producer/consumer side.
interface compressor_if
  import sparse_pkg::*;
#(
  parameter int WORD_L     = DEF_WORD_L,
  parameter int IN_PORT_L  = DEF_IN_PORT_L,
  parameter int OUT_PORT_L = DEF_OUT_PORT_L
);
  logic                                dense_valid;
  logic                                dense_ready;
  logic [OUT_PORT_L-1:0][WORD_L-1:0]   dense_inputs;
  logic                                comp_valid;
  logic                                comp_ready;
  logic [OUT_PORT_L-1:0]               header;
  logic [IN_PORT_L-1:0][WORD_L-1:0]    compressed_outputs;
  logic                                last;

  modport slave (
    input  dense_valid, dense_inputs, comp_ready,
    output dense_ready, comp_valid, header, compressed_outputs, last
  );

  modport master (
    output dense_valid, dense_inputs, comp_ready,
    input  dense_ready, comp_valid, header, compressed_outputs, last
  );
endinterface

// File: rtl/lowest_set_select.sv
// Combinational pick of the lowest IN_PORT_L set bits of a mask, with the lane each one maps to.
// Zero latency, no state; lane numbering follows sparse_pkg::lane_of_rank.
module lowest_set_select
  import sparse_pkg::*;
#(
  parameter int IN_PORT_L  = DEF_IN_PORT_L,
  parameter int OUT_PORT_L = DEF_OUT_PORT_L,
  localparam int CNT_W     = $clog2(OUT_PORT_L + 1),
  localparam int LANE_W    = $clog2(IN_PORT_L)
) (
  input  logic [OUT_PORT_L-1:0]             i_pending,
  output logic [OUT_PORT_L-1:0]             o_header,
  output logic [OUT_PORT_L-1:0][LANE_W-1:0] o_lane
);
  localparam logic [CNT_W-1:0] RANK_LIM = CNT_W'(IN_PORT_L);

  logic [CNT_W-1:0] w_rank;

  always_comb begin
    w_rank   = '0;
    o_header = '0;
    o_lane   = '0;
    for (int i = 0; i < OUT_PORT_L; i++) begin
      if (i_pending[i] && (w_rank < RANK_LIM)) begin
        o_header[i] = 1'b1;
        o_lane[i]   = LANE_W'(lane_of_rank(int'(w_rank), IN_PORT_L));
        w_rank      = w_rank + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/compressor.sv
// Zero-skipping compressor: one dense vector in, max(1, ceil(nnz/IN_PORT_L)) beats out, first beat
// the cycle after accept; under comp_ready low the held beat stays bit-stable and dense_ready drops.
module compressor
  import sparse_pkg::*;
#(
  parameter int WORD_L     = DEF_WORD_L,
  parameter int IN_PORT_L  = DEF_IN_PORT_L,
  parameter int OUT_PORT_L = DEF_OUT_PORT_L
) (
  input  logic         clk,
  input  logic         rst,
  compressor_if.slave  comp_if
);
  localparam int LANE_W = $clog2(IN_PORT_L);

  comp_state_t                          r_state;
  comp_state_t                          w_state_nxt;
  logic [OUT_PORT_L-1:0][WORD_L-1:0]    r_vec;
  logic [OUT_PORT_L-1:0]                r_pending;
  logic [OUT_PORT_L-1:0]                w_mask;
  logic [OUT_PORT_L-1:0]                w_header;
  logic [OUT_PORT_L-1:0][LANE_W-1:0]    w_lane;
  logic [IN_PORT_L-1:0][WORD_L-1:0]     w_lanes;
  logic                                 w_comp_valid;
  logic                                 w_dense_ready;
  logic                                 w_last;
  logic                                 w_accept;
  logic                                 w_fire;

  lowest_set_select #(
    .IN_PORT_L  (IN_PORT_L),
    .OUT_PORT_L (OUT_PORT_L)
  ) u_sel (
    .i_pending (r_pending),
    .o_header  (w_header),
    .o_lane    (w_lane)
  );

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < OUT_PORT_L; i++) begin
      w_mask[i] = |comp_if.dense_inputs[i];
    end
  end

  assign w_last = ((r_pending & ~w_header) == '0);

  // A last-beat handshake frees the slot in the same cycle, so a new vector loads without a bubble.
  always_comb begin
    w_state_nxt   = r_state;
    w_comp_valid  = 1'b0;
    w_dense_ready = 1'b1;
    case (r_state)
      EMPTY: begin
        if (comp_if.dense_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        w_comp_valid  = 1'b1;
        w_dense_ready = comp_if.comp_ready && w_last;
        if (comp_if.comp_ready && w_last && !comp_if.dense_valid) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign w_accept = comp_if.dense_valid && w_dense_ready;
  assign w_fire   = w_comp_valid && comp_if.comp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec     <= '0;
      r_pending <= '0;
    end else if (w_accept) begin
      r_vec     <= comp_if.dense_inputs;
      r_pending <= w_mask;
    end else if (w_fire) begin
      r_pending <= r_pending & ~w_header;
    end
  end

  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < OUT_PORT_L; i++) begin
      if (w_header[i]) w_lanes[w_lane[i]] = r_vec[i];
    end
  end

  assign comp_if.dense_ready        = w_dense_ready;
  assign comp_if.comp_valid         = w_comp_valid;
  assign comp_if.header             = w_comp_valid ? w_header : '0;
  assign comp_if.compressed_outputs = w_comp_valid ? w_lanes : '0;
  assign comp_if.last               = w_comp_valid && w_last;
endmodule

// File: tb/tb_compressor.sv
// Directed and random checks of compressor with a beat scoreboard and a decompress-and-OR round trip.
module tb_compressor;
  import sparse_pkg::*;

  typedef logic [7:0][7:0] vec_t;
  typedef struct packed {
    logic [7:0]      hdr;
    logic [3:0][7:0] lanes;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  beat_t exp_q[$];
  vec_t  dense_q[$];
  vec_t  rt_acc = '0;
  int    rt_beats = 0;

  compressor_if #(.WORD_L(8), .IN_PORT_L(4), .OUT_PORT_L(8)) u_if ();

  compressor #(.WORD_L(8), .IN_PORT_L(4), .OUT_PORT_L(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .comp_if (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input vec_t v);
    int    pos[$];
    int    nb;
    int    idx;
    beat_t b;
    for (int i = 0; i < 8; i++) if (v[i] != 8'h00) pos.push_back(i);
    nb = (pos.size() == 0) ? 1 : (pos.size() + 3) / 4;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int k = 0; k < 4; k++) begin
        idx = bi * 4 + k;
        if (idx < pos.size()) begin
          b.hdr[pos[idx]]      = 1'b1;
          b.lanes[(k + 1) % 4] = v[pos[idx]];
        end
      end
      b.last = (bi == nb - 1);
      exp_q.push_back(b);
    end
    dense_q.push_back(v);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    dense_q.delete();
    rt_acc   = '0;
    rt_beats = 0;
  endtask

  // One clock: sample at negedge (score a firing beat, record an accept), then step past posedge.
  task automatic step(output bit accepted);
    beat_t           e;
    vec_t            dec;
    vec_t            dv;
    logic [3:0][7:0] ln;
    int              c;
    int              nnz;
    @(negedge clk);
    accepted = u_if.dense_valid && u_if.dense_ready;
    if (u_if.comp_valid && u_if.comp_ready) begin
      check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      ln = u_if.compressed_outputs;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_header", 64'(u_if.header), 64'(e.hdr));
        check("sb_lanes", 64'(ln), 64'(e.lanes));
        check("sb_last", 64'(u_if.last), 64'(e.last));
      end
      dec = '0;
      c   = 0;
      for (int i = 0; i < 8; i++) begin
        if (u_if.header[i]) begin
          c++;
          dec[i] = ln[c % 4];
        end
      end
      rt_acc = rt_acc | dec;
      rt_beats++;
      if (u_if.last) begin
        check("rt_vec_expected", 64'(dense_q.size() > 0), 64'd1);
        if (dense_q.size() > 0) begin
          dv  = dense_q.pop_front();
          nnz = 0;
          for (int i = 0; i < 8; i++) if (dv[i] != 8'h00) nnz++;
          check("rt_or", 64'(rt_acc), 64'(dv));
          check("rt_beats", 64'(rt_beats), 64'((nnz == 0) ? 1 : (nnz + 3) / 4));
        end
        rt_acc   = '0;
        rt_beats = 0;
      end
    end
    if (accepted) push_model(u_if.dense_inputs);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t sparse_vec();
    vec_t v = '0;
    for (int p = 0; p < 4; p++) v[$urandom_range(7)] = 8'($urandom_range(255, 1));
    return v;
  endfunction

  initial begin
    bit    acc;
    vec_t  v;
    word_t w;
    vec_t  seq8;
    for (int i = 0; i < 8; i++) seq8[i] = 8'(i + 1);

    u_if.dense_valid  = 1'b0;
    u_if.dense_inputs = '0;
    u_if.comp_ready   = 1'b0;

    // Reset state
    #3;
    check("rst_comp_valid", 64'(u_if.comp_valid), 64'd0);
    check("rst_dense_ready", 64'(u_if.dense_ready), 64'd1);
    check("rst_header", 64'(u_if.header), 64'd0);
    check("rst_lanes", 64'(u_if.compressed_outputs), 64'd0);
    check("rst_last", 64'(u_if.last), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Case 1: three non-zeros, single beat
    u_if.comp_ready   = 1'b1;
    u_if.dense_inputs = {8'h00, 8'h33, 8'h00, 8'h00, 8'h22, 8'h00, 8'h11, 8'h00};
    u_if.dense_valid  = 1'b1;
    step(acc);
    check("c1_accept", 64'(acc), 64'd1);
    u_if.dense_valid = 1'b0;
    check("c1_valid", 64'(u_if.comp_valid), 64'd1);
    check("c1_header", 64'(u_if.header), 64'h4A);
    check("c1_lanes", 64'(u_if.compressed_outputs), 64'h33221100);
    check("c1_last", 64'(u_if.last), 64'd1);
    step(acc);
    check("c1_done", 64'(u_if.comp_valid), 64'd0);

    // Case 2: fully dense, two beats
    u_if.dense_inputs = seq8;
    u_if.dense_valid  = 1'b1;
    step(acc);
    u_if.dense_valid = 1'b0;
    check("c2_b1_header", 64'(u_if.header), 64'h0F);
    check("c2_b1_lanes", 64'(u_if.compressed_outputs), 64'h03020104);
    check("c2_b1_last", 64'(u_if.last), 64'd0);
    check("c2_b1_dense_ready", 64'(u_if.dense_ready), 64'd0);
    step(acc);
    check("c2_b2_header", 64'(u_if.header), 64'hF0);
    check("c2_b2_lanes", 64'(u_if.compressed_outputs), 64'h07060508);
    check("c2_b2_last", 64'(u_if.last), 64'd1);
    step(acc);
    check("c2_done", 64'(u_if.comp_valid), 64'd0);

    // Case 3: all-zero vector
    u_if.dense_inputs = '0;
    u_if.dense_valid  = 1'b1;
    step(acc);
    u_if.dense_valid = 1'b0;
    check("c3_valid", 64'(u_if.comp_valid), 64'd1);
    check("c3_header", 64'(u_if.header), 64'd0);
    check("c3_lanes", 64'(u_if.compressed_outputs), 64'd0);
    check("c3_last", 64'(u_if.last), 64'd1);
    step(acc);
    check("c3_done", 64'(u_if.comp_valid), 64'd0);

    // Case 4a: backpressure on the first beat
    u_if.comp_ready   = 1'b0;
    u_if.dense_inputs = seq8;
    u_if.dense_valid  = 1'b1;
    step(acc);
    u_if.dense_valid  = 1'b0;
    u_if.dense_inputs = '1;
    for (int t = 0; t < 3; t++) begin
      check("c4_bp_valid", 64'(u_if.comp_valid), 64'd1);
      check("c4_bp_header", 64'(u_if.header), 64'h0F);
      check("c4_bp_lanes", 64'(u_if.compressed_outputs), 64'h03020104);
      check("c4_bp_last", 64'(u_if.last), 64'd0);
      check("c4_bp_dense_ready", 64'(u_if.dense_ready), 64'd0);
      step(acc);
    end
    u_if.comp_ready = 1'b1;
    step(acc);
    step(acc);
    check("c4_bp_done", 64'(u_if.comp_valid), 64'd0);

    // Case 4b: ten back-to-back sparse vectors
    for (int k = 0; k < 10; k++) begin
      u_if.dense_inputs = sparse_vec();
      u_if.dense_valid  = 1'b1;
      check("c4_stream_dense_ready", 64'(u_if.dense_ready), 64'd1);
      if (k > 0) check("c4_stream_valid", 64'(u_if.comp_valid), 64'd1);
      step(acc);
      check("c4_stream_accept", 64'(acc), 64'd1);
    end
    u_if.dense_valid = 1'b0;
    step(acc);
    check("c4_stream_done", 64'(u_if.comp_valid), 64'd0);
    check("c4_stream_sb_empty", 64'(exp_q.size()), 64'd0);

    // Case 5: reset in the middle of a two-beat vector
    u_if.dense_inputs = seq8;
    u_if.dense_valid  = 1'b1;
    step(acc);
    u_if.dense_valid = 1'b0;
    step(acc);
    check("c5_beat2_pending", 64'(u_if.header), 64'hF0);
    #2;
    rst = 1'b1;
    #1;
    clear_sb();
    check("c5_rst_valid", 64'(u_if.comp_valid), 64'd0);
    check("c5_rst_header", 64'(u_if.header), 64'd0);
    check("c5_rst_lanes", 64'(u_if.compressed_outputs), 64'd0);
    check("c5_rst_dense_ready", 64'(u_if.dense_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check("c5_post_valid", 64'(u_if.comp_valid), 64'd0);
      check("c5_post_dense_ready", 64'(u_if.dense_ready), 64'd1);
      step(acc);
    end

    // Case 6: random round trip
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 8; i++) begin
        w    = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        v[i] = w;
      end
      u_if.dense_inputs = v;
      u_if.dense_valid  = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        u_if.comp_ready = ($urandom_range(3) != 0);
        step(acc);
      end
      check("c6_accept", 64'(acc), 64'd1);
      if ($urandom_range(7) == 0) begin
        u_if.dense_valid = 1'b0;
        u_if.comp_ready  = ($urandom_range(3) != 0);
        step(acc);
      end
    end
    u_if.dense_valid = 1'b0;
    u_if.comp_ready  = 1'b1;
    for (int t = 0; t < 32 && u_if.comp_valid; t++) step(acc);
    check("c6_drained", 64'(u_if.comp_valid), 64'd0);
    check("c6_sb_empty", 64'(exp_q.size()), 64'd0);
    check("c6_dense_q_empty", 64'(dense_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
